dphy_lane_tx_seq: RTL and testbench

- Parametrised multi-lane D-PHY data-lane transmit sequencer and output stage.
- Drives per-lane P/N line states and the HS/LP select through the full LP-11 → LP-01 → LP-00 → HS-zero → sync → data → trail → LP-11 burst sequence, with programmable timing.
- Sits between the lane distributor (bit-serial HS data per lane) and the pad drivers.
- All pin outputs are registered.

---
 rtl/dphy_tx_pkg.sv | 26 ++
 rtl/dphy_seq_timer.sv | 29 ++
 rtl/dphy_lane_tx_seq.sv | 133 +++++++++++++
 tb/tb_dphy_lane_tx_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dphy_tx_pkg.sv
// rtl/dphy_tx_pkg.sv - shared state encoding and line codes for the D-PHY lane transmit sequencer
package dphy_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LP01    = 3'd1,
    ST_LP00    = 3'd2,
    ST_HS_ZERO = 3'd3,
    ST_SYNC    = 3'd4,
    ST_DATA    = 3'd5,
    ST_TRAIL   = 3'd6
  } seq_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;
  localparam logic [2:0] SYNC_LAST = 3'd7;

  // Line codes are {p, n}
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  function automatic logic is_hs_state(input seq_state_e s);
    return (s == ST_HS_ZERO) || (s == ST_SYNC) || (s == ST_DATA) || (s == ST_TRAIL);
  endfunction

endpackage

// File: rtl/dphy_seq_timer.sv
// rtl/dphy_seq_timer.sv - loadable down-counter; a load of N (0 read as 1) raises done after N cycles
module dphy_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt;

  // The loading cycle counts as the first of the N cycles, so store N-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_val == '0) ? '0 : load_val - ONE;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/dphy_lane_tx_seq.sv
// rtl/dphy_lane_tx_seq.sv - multi-lane D-PHY data-lane burst sequencer with registered pad outputs
module dphy_lane_tx_seq
  import dphy_tx_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] lane_en,
  input  logic                 hs_req,
  input  logic [NUM_LANES-1:0] hs_data,
  output logic                 hs_ready,
  input  logic [CNT_W-1:0]     t_lpx,
  input  logic [CNT_W-1:0]     t_hs_prepare,
  input  logic [CNT_W-1:0]     t_hs_zero,
  input  logic [CNT_W-1:0]     t_hs_trail,
  output logic [NUM_LANES-1:0] p,
  output logic [NUM_LANES-1:0] n,
  output logic [NUM_LANES-1:0] hs_sel,
  output logic                 busy
);

  seq_state_e       state;
  seq_state_e       next_state;
  logic             timer_done;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic [2:0]       sync_idx;
  logic [2:0]       sync_idx_d;
  logic             consume;
  logic             sync_bit_d;

  dphy_seq_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .load_val(timer_val),
    .done    (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sync_idx <= '0;
    end else begin
      state    <= next_state;
      sync_idx <= (next_state == ST_SYNC) ? sync_idx_d : '0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (hs_req) next_state = ST_LP01;
      ST_LP01:    if (!hs_req) next_state = ST_IDLE;
                  else if (timer_done) next_state = ST_LP00;
      ST_LP00:    if (!hs_req) next_state = ST_IDLE;
                  else if (timer_done) next_state = ST_HS_ZERO;
      ST_HS_ZERO: if (timer_done) next_state = ST_SYNC;
      ST_SYNC:    if (sync_idx == SYNC_LAST) next_state = hs_req ? ST_DATA : ST_TRAIL;
      ST_DATA:    if (!hs_req) next_state = ST_TRAIL;
      ST_TRAIL:   if (timer_done) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    hs_ready   = (state == ST_DATA);
    busy       = (state != ST_IDLE);
    consume    = (state == ST_DATA) && hs_req;
    sync_idx_d = (state == ST_SYNC) ? sync_idx + 3'd1 : 3'd0;
    sync_bit_d = SYNC_BYTE[sync_idx_d];
    timer_load = (next_state != state);
    case (next_state)
      ST_LP01:    timer_val = t_lpx;
      ST_LP00:    timer_val = t_hs_prepare;
      ST_HS_ZERO: timer_val = t_hs_zero;
      ST_TRAIL:   timer_val = t_hs_trail;
      default:    timer_val = '0;
    endcase
  end

  // Per-lane pad register; pins follow next_state so they change on the same edge as state
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic       last_bit;
    logic       bit_d;
    logic       sel_d;
    logic [1:0] line_d;

    always_comb begin
      bit_d  = 1'b0;
      sel_d  = 1'b0;
      line_d = LP11;
      case (next_state)
        ST_IDLE:    line_d = LP11;
        ST_LP01:    line_d = LP01;
        ST_LP00:    line_d = LP00;
        ST_HS_ZERO: bit_d  = 1'b0;
        ST_SYNC:    bit_d  = sync_bit_d;
        // First DATA cycle has nothing consumed yet, so the last sync bit is held
        ST_DATA:    bit_d  = consume ? hs_data[i] : last_bit;
        ST_TRAIL:   bit_d  = ~last_bit;
        default:    line_d = LP11;
      endcase
      if (is_hs_state(next_state)) begin
        sel_d  = 1'b1;
        line_d = {bit_d, ~bit_d};
      end
      if (!lane_en[i]) begin
        sel_d  = 1'b0;
        line_d = LP11;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p[i]      <= 1'b1;
        n[i]      <= 1'b1;
        hs_sel[i] <= 1'b0;
        last_bit  <= 1'b0;
      end else begin
        p[i]      <= line_d[1];
        n[i]      <= line_d[0];
        hs_sel[i] <= sel_d;
        if ((next_state == ST_SYNC) || (next_state == ST_DATA)) last_bit <= bit_d;
      end
    end
  end

endmodule

// File: tb/tb_dphy_lane_tx_seq.sv
// tb/tb_dphy_lane_tx_seq.sv - scoreboard bench for dphy_lane_tx_seq
module tb_dphy_lane_tx_seq;

  localparam int NL = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NL-1:0] lane_en;
  logic          hs_req;
  logic [NL-1:0] hs_data;
  logic          hs_ready;
  logic [CW-1:0] t_lpx, t_hs_prepare, t_hs_zero, t_hs_trail;
  logic [NL-1:0] p, n, hs_sel;
  logic          busy;

  typedef struct packed {
    logic [NL-1:0] p;
    logic [NL-1:0] n;
    logic [NL-1:0] sel;
    logic          ready;
    logic          busy;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  dphy_lane_tx_seq #(.NUM_LANES(NL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .lane_en(lane_en), .hs_req(hs_req), .hs_data(hs_data),
    .hs_ready(hs_ready), .t_lpx(t_lpx), .t_hs_prepare(t_hs_prepare),
    .t_hs_zero(t_hs_zero), .t_hs_trail(t_hs_trail), .p(p), .n(n),
    .hs_sel(hs_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.p = p; o.n = n; o.sel = hs_sel; o.ready = hs_ready; o.busy = busy;
    return o;
  endfunction

  function automatic obs_t idle_vec();
    obs_t o;
    o.p = '1; o.n = '1; o.sel = '0; o.ready = 1'b0; o.busy = 1'b0;
    return o;
  endfunction

  function automatic obs_t lp_vec(input logic [NL-1:0] en, input logic pv, input logic nv);
    obs_t o;
    for (int i = 0; i < NL; i++) begin
      o.p[i]   = en[i] ? pv : 1'b1;
      o.n[i]   = en[i] ? nv : 1'b1;
      o.sel[i] = 1'b0;
    end
    o.ready = 1'b0; o.busy = 1'b1;
    return o;
  endfunction

  function automatic obs_t hs_vec(input logic [NL-1:0] en, input logic [NL-1:0] bits, input logic rdy);
    obs_t o;
    for (int i = 0; i < NL; i++) begin
      o.p[i]   = en[i] ? bits[i] : 1'b1;
      o.n[i]   = en[i] ? ~bits[i] : 1'b1;
      o.sel[i] = en[i];
    end
    o.ready = rdy; o.busy = 1'b1;
    return o;
  endfunction

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // One burst: hs_req high for the first h edges; k counts edges from the first one that sees hs_req
  task automatic run_burst(input string name, input int tl, input int tp, input int tz, input int tt,
                           input int h, input logic [NL-1:0] en, input bit rnd, input logic [NL-1:0] fixed);
    int L, P, Z, T, D, trail_start, end_k, total;
    bit abort;
    logic [7:0] sb;
    logic [NL-1:0] last, bits;
    obs_t e, got;
    sb = 8'hB8;
    L = eff(tl); P = eff(tp); Z = eff(tz); T = eff(tt);
    D = L + P + Z + 8;
    abort = (h <= L + P);
    trail_start = (h <= D) ? D : h;
    end_k = abort ? h : trail_start + T;
    total = end_k + 3;
    t_lpx = CW'(tl); t_hs_prepare = CW'(tp); t_hs_zero = CW'(tz); t_hs_trail = CW'(tt);
    lane_en = en;
    last = '1;
    for (int k = 0; k < total; k++) begin
      hs_req  = (k < h);
      hs_data = rnd ? NL'($urandom) : fixed;
      if (k >= end_k)                 e = idle_vec();
      else if (k < L)                 e = lp_vec(en, 1'b0, 1'b1);
      else if (k < L + P)             e = lp_vec(en, 1'b0, 1'b0);
      else if (k < L + P + Z)         e = hs_vec(en, '0, 1'b0);
      else if (k < D) begin
        bits = {NL{sb[k - (L + P + Z)]}};
        last = bits;
        e = hs_vec(en, bits, 1'b0);
      end else if (k < trail_start) begin
        bits = (k == D) ? last : hs_data;
        last = bits;
        e = hs_vec(en, bits, 1'b1);
      end else                        e = hs_vec(en, ~last, 1'b0);
      exp_q.push_back(e);
      @(posedge clk); #1;
      got = observe();
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d]", name, k), 32'(got), 32'(e));
    end
    hs_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lane_en = '1; hs_req = 1'b0; hs_data = '0;
    t_lpx = '0; t_hs_prepare = '0; t_hs_zero = '0; t_hs_trail = '0;
    #12;
    chk("reset_in", 32'(observe()), 32'(idle_vec()));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_out", 32'(observe()), 32'(idle_vec()));

    run_burst("basic",      3, 2, 4, 5, 20, 2'b11, 1'b0, 2'b10);
    run_burst("abort_lp00", 3, 2, 4, 5,  4, 2'b11, 1'b0, 2'b10);
    run_burst("abort_lp01", 3, 2, 4, 5,  2, 2'b11, 1'b0, 2'b01);
    run_burst("drop_zero",  3, 2, 4, 5,  7, 2'b11, 1'b0, 2'b11);
    run_burst("drop_sync",  2, 1, 1, 3, 10, 2'b11, 1'b0, 2'b11);
    run_burst("zero_cnt",   0, 0, 0, 0, 15, 2'b11, 1'b1, 2'b00);
    run_burst("lane_dis",   3, 2, 4, 5, 22, 2'b01, 1'b1, 2'b00);
    run_burst("sync_end",   1, 1, 1, 2, 12, 2'b10, 1'b0, 2'b00);
    for (int r = 0; r < 6; r++)
      run_burst($sformatf("rand%0d", r), $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(1, 30),
                NL'($urandom_range(1, 3)), 1'b1, 2'b00);

    // Asynchronous reset while in DATA
    t_lpx = 8'd3; t_hs_prepare = 8'd2; t_hs_zero = 8'd4; t_hs_trail = 8'd5;
    lane_en = '1; hs_req = 1'b1; hs_data = 2'b10;
    repeat (19) @(posedge clk);
    #1;
    chk("pre_rst_ready", 32'(hs_ready), 32'(1'b1));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_data", 32'(observe()), 32'(idle_vec()));
    @(posedge clk); #1;
    rst = 1'b0; hs_req = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(observe()), 32'(idle_vec()));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
